// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter and its write buffer.
package dm_arb_pkg;

    // One parked committed store.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bmask;
        logic        valid;
    } wb_entry_t;

    // DM bit write enables are active-low, so all-ones means "write nothing".
    localparam logic [31:0] DM_WEN_NONE = 32'hFFFF_FFFF;
    localparam int          LANE_W      = 8;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the LSU load port, committed-store port and data-memory port.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface dm_port_arbiter_if;

    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [1:0]  ld_req_tag;
    logic        ld_resp_valid;
    logic [1:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_bmask;
    logic        wb_empty;

    logic [31:0] DM_rd_data;
    logic        DM_c_en;
    logic        DM_r_en;
    logic [31:0] DM_w_en;
    logic [31:0] DM_addr;
    logic [31:0] DM_w_data;

    modport slave (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        output ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
        input  st_valid, st_addr, st_data, st_bmask,
        output st_ready, wb_empty,
        input  DM_rd_data,
        output DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data
    );

    modport master (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        input  ld_req_ready, ld_resp_valid, ld_resp_tag, ld_resp_data,
        output st_valid, st_addr, st_data, st_bmask,
        input  st_ready, wb_empty,
        output DM_rd_data,
        input  DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data
    );

endinterface

// File: rtl/dm_write_buffer.sv
// Circular FIFO of committed stores with a per-entry word-address compare.
// With WB_FWD_EN defined it also reports the youngest matching entry for forwarding.
module dm_write_buffer
    import dm_arb_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [31:0]                 push_addr,
    input  logic [31:0]                 push_data,
    input  logic [3:0]                  push_bmask,
    input  logic                        pop,
    output wb_entry_t                   head_entry,
    output logic [$clog2(WB_DEPTH):0]   count,
    input  logic [29:0]                 cmp_word,
`ifdef WB_FWD_EN
    output logic                        fwd_full,
    output logic [31:0]                 fwd_data,
`endif
    output logic [WB_DEPTH-1:0]         match_vec
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    wb_entry_t           entry_reg [WB_DEPTH];
    logic [PTR_W-1:0]    head_reg;
    logic [PTR_W-1:0]    tail_reg;
    logic [PTR_W:0]      count_reg;

    // Pointers wrap naturally because the depth is a power of two; count disambiguates full/empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Entry storage: push writes at tail, pop retires the head entry's valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WB_DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (push && tail_reg == PTR_W'(i)) begin
                    entry_reg[i] <= '{addr: push_addr, data: push_data,
                                      bmask: push_bmask, valid: 1'b1};
                end else if (pop && head_reg == PTR_W'(i)) begin
                    entry_reg[i].valid <= 1'b0;
                end
            end
        end
    end

    // Word-granular hazard compare against every live entry.
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_match
        assign match_vec[gi] = entry_reg[gi].valid && (entry_reg[gi].addr[31:2] == cmp_word);
    end

    assign head_entry = entry_reg[head_reg];
    assign count      = count_reg;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] scan_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_full = 1'b0;
        fwd_data = '0;
        scan_idx = head_reg;
        for (int k = 0; k < WB_DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (match_vec[scan_idx]) begin
                fwd_full = &entry_reg[scan_idx].bmask;
                fwd_data = entry_reg[scan_idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between LSU loads and committed-store drain.
// Loads win by default; a drain is forced on full WB, starvation, address conflict
// or an idle load port. Optional macro WB_FWD_EN enables full-word store-to-load
// forwarding from the write buffer.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WB_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic              clk,
    input logic              rst,
    dm_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(WB_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t           head_entry;
    logic [CNT_W-1:0]    wb_count;
    logic [WB_DEPTH-1:0] match_vec;
    logic                wb_push;
    logic                wb_nonempty;
    logic                wb_full;
    logic                conflict;
    logic                fwd_hit;
    logic                blocked;
    logic                drain;
    logic                ld_dm_grant;
    logic                fwd_grant;
    logic                ld_grant;
    logic [31:0]         drain_wen;
    logic                dm_c_en;
    logic                dm_r_en;
    logic [31:0]         dm_w_en;
    logic [31:0]         dm_addr;
    logic [31:0]         dm_w_data;
    logic [STV_W-1:0]    starve_reg;
    logic                resp_valid_reg;
    logic [1:0]          resp_tag_reg;
    logic                unused_bits;
`ifdef WB_FWD_EN
    logic                wb_fwd_full;
    logic [31:0]         wb_fwd_data;
    logic                fwd_sel_reg;
    logic [31:0]         fwd_data_reg;
`endif

    assign wb_nonempty = (wb_count != '0);
    assign wb_full     = (wb_count == CNT_W'(WB_DEPTH));
    assign wb_push     = bus.st_valid && !wb_full;

    dm_write_buffer #(
        .WB_DEPTH (WB_DEPTH)
    ) u_wb (
        .clk        (clk),
        .rst        (rst),
        .push       (wb_push),
        .push_addr  (bus.st_addr),
        .push_data  (bus.st_data),
        .push_bmask (bus.st_bmask),
        .pop        (drain),
        .head_entry (head_entry),
        .count      (wb_count),
        .cmp_word   (bus.ld_req_addr[31:2]),
`ifdef WB_FWD_EN
        .fwd_full   (wb_fwd_full),
        .fwd_data   (wb_fwd_data),
`endif
        .match_vec  (match_vec)
    );

    assign conflict = |match_vec;
`ifdef WB_FWD_EN
    assign fwd_hit  = conflict && wb_fwd_full;
`else
    assign fwd_hit  = 1'b0;
`endif
    assign blocked  = conflict && !fwd_hit;

    // Active-low byte-lane write enables for the head entry.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign drain_wen[gi*LANE_W +: LANE_W] = {LANE_W{~head_entry.bmask[gi]}};
    end

    // Grant decision; a forwarded load leaves the port free, so the head drains alongside it.
    always_comb begin
        drain       = wb_nonempty && (wb_full || (starve_reg == STV_W'(STARVE_LIMIT)) ||
                                      !bus.ld_req_valid || blocked || fwd_hit);
        ld_dm_grant = bus.ld_req_valid && !drain;
        fwd_grant   = bus.ld_req_valid && fwd_hit;
        ld_grant    = ld_dm_grant || fwd_grant;
    end

    // DM port drive: drain, load read, or idle.
    always_comb begin
        dm_c_en   = 1'b0;
        dm_r_en   = 1'b1;
        dm_w_en   = DM_WEN_NONE;
        dm_addr   = '0;
        dm_w_data = '0;
        if (drain) begin
            dm_c_en   = 1'b1;
            dm_r_en   = 1'b0;
            dm_w_en   = drain_wen;
            dm_addr   = {head_entry.addr[31:2], 2'b00};
            dm_w_data = head_entry.data;
        end else if (ld_dm_grant) begin
            dm_c_en   = 1'b1;
            dm_addr   = {bus.ld_req_addr[31:2], 2'b00};
        end
    end

    // Starvation counter: counts loads that beat a waiting WB, saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_reg <= '0;
        end else if (drain || !wb_nonempty) begin
            starve_reg <= '0;
        end else if (ld_dm_grant && starve_reg != STV_W'(STARVE_LIMIT)) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

    // Response pipeline stage; data arrives from DM (or the forward latch) one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_reg <= 1'b0;
            resp_tag_reg   <= '0;
`ifdef WB_FWD_EN
            fwd_sel_reg    <= 1'b0;
            fwd_data_reg   <= '0;
`endif
        end else begin
            resp_valid_reg <= ld_grant;
            if (ld_grant) resp_tag_reg <= bus.ld_req_tag;
`ifdef WB_FWD_EN
            fwd_sel_reg    <= fwd_grant;
            if (fwd_grant) fwd_data_reg <= wb_fwd_data;
`endif
        end
    end

    assign bus.ld_req_ready  = ld_grant;
    assign bus.ld_resp_valid = resp_valid_reg;
    assign bus.ld_resp_tag   = resp_tag_reg;
`ifdef WB_FWD_EN
    assign bus.ld_resp_data  = !resp_valid_reg ? 32'h0 :
                               (fwd_sel_reg ? fwd_data_reg : bus.DM_rd_data);
`else
    assign bus.ld_resp_data  = resp_valid_reg ? bus.DM_rd_data : 32'h0;
`endif
    assign bus.st_ready      = !wb_full;
    assign bus.wb_empty      = !wb_nonempty;
    assign bus.DM_c_en       = dm_c_en;
    assign bus.DM_r_en       = dm_r_en;
    assign bus.DM_w_en       = dm_w_en;
    assign bus.DM_addr       = dm_addr;
    assign bus.DM_w_data     = dm_w_data;

    // Byte-offset bits and the head valid flag carry no information for the port.
    assign unused_bits = ^{bus.ld_req_addr[1:0], head_entry.addr[1:0], head_entry.valid};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: expected DM accesses and load responses are
// queued by the stimulus and consumed by an independent monitor.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus();

    dm_port_arbiter #(
        .WB_DEPTH     (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        r_en;
        logic [31:0] addr;
        logic [31:0] w_en;
        logic [31:0] w_data;
    } dm_t;

    resp_t resp_q[$];
    dm_t   dm_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    // Simple DM model with a preload port.
    logic [31:0] mem [0:1023];
    logic [31:0] dm_rd = '0;
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr[11:2]] <= pre_data;
        end else if (bus.DM_c_en === 1'b1) begin
            if (bus.DM_r_en) dm_rd <= mem[bus.DM_addr[11:2]];
            else mem[bus.DM_addr[11:2]] <= (mem[bus.DM_addr[11:2]] & bus.DM_w_en) |
                                           (bus.DM_w_data & ~bus.DM_w_en);
        end
    end
    assign bus.DM_rd_data = dm_rd;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void exp_rd(input logic [31:0] a);
        dm_q.push_back('{r_en: 1'b1, addr: a, w_en: DM_WEN_NONE, w_data: 32'h0});
    endfunction

    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] wen, input logic [31:0] d);
        dm_q.push_back('{r_en: 1'b0, addr: a, w_en: wen, w_data: d});
    endfunction

    function automatic void exp_resp(input logic [1:0] t, input logic [31:0] d);
        resp_q.push_back('{tag: t, data: d});
    endfunction

    // Monitor: every DM access and load response is matched against the queues.
    always @(negedge clk) begin
        resp_t er;
        dm_t   ed;
        if (mon_en) begin
            if (bus.ld_resp_valid !== 1'b0) begin
                if (resp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp_unexpected: got tag %0d data %h, required no response",
                             bus.ld_resp_tag, bus.ld_resp_data);
                end else begin
                    er = resp_q.pop_front();
                    $display("[%0t] resp tag=%0d data=%h", $time, bus.ld_resp_tag, bus.ld_resp_data);
                    check("resp_tag", {30'h0, bus.ld_resp_tag}, {30'h0, er.tag});
                    check("resp_data", bus.ld_resp_data, er.data);
                end
            end
            if (bus.DM_c_en !== 1'b0) begin
                if (dm_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dm_unexpected: got access r_en=%b addr %h, required no access",
                             bus.DM_r_en, bus.DM_addr);
                end else begin
                    ed = dm_q.pop_front();
                    $display("[%0t] dm %s addr=%h w_en=%h w_data=%h", $time,
                             bus.DM_r_en ? "rd" : "wr", bus.DM_addr, bus.DM_w_en, bus.DM_w_data);
                    check("dm_r_en", {31'h0, bus.DM_r_en}, {31'h0, ed.r_en});
                    check("dm_addr", bus.DM_addr, ed.addr);
                    check("dm_w_en", bus.DM_w_en, ed.w_en);
                    if (!ed.r_en) check("dm_w_data", bus.DM_w_data, ed.w_data);
                end
            end
        end
    end

    task automatic drive(input logic lv, input logic [31:0] la, input logic [1:0] lt,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sb);
        bus.ld_req_valid = lv;
        bus.ld_req_addr  = la;
        bus.ld_req_tag   = lt;
        bus.st_valid     = sv;
        bus.st_addr      = sa;
        bus.st_data      = sd;
        bus.st_bmask     = sb;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // One cycle: inputs already driven; check handshakes mid-cycle, then advance.
    task automatic cyc(input string name, input logic exp_rdy, input logic exp_st_rdy, input int exp_empty);
        @(negedge clk);
        check({name, "_ld_ready"}, {31'h0, bus.ld_req_ready}, {31'h0, exp_rdy});
        check({name, "_st_ready"}, {31'h0, bus.st_ready}, {31'h0, exp_st_rdy});
        if (exp_empty >= 0) check({name, "_wb_empty"}, {31'h0, bus.wb_empty}, 32'(exp_empty));
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h104, 32'hCAFEF00D);
        preload(32'h108, 32'h01234567);
        preload(32'h10C, 32'h89ABCDEF);
        preload(32'h200, 32'h55555555);
        preload(32'h300, 32'hAAAAAAAA);
        preload(32'h600, 32'h12345678);

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", {31'h0, bus.ld_resp_valid}, 32'h0);
        check("rst_resp_tag", {30'h0, bus.ld_resp_tag}, 32'h0);
        check("rst_resp_data", bus.ld_resp_data, 32'h0);
        check("rst_wb_empty", {31'h0, bus.wb_empty}, 32'h1);
        check("rst_st_ready", {31'h0, bus.st_ready}, 32'h1);
        check("rst_dm_c_en", {31'h0, bus.DM_c_en}, 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Lone load
        drive(1'b1, 32'h100, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd(32'h100); exp_resp(2'd2, 32'hDEADBEEF);
        cyc("lone_load", 1'b1, 1'b1, 1);
        idle(); cyc("lone_resp", 1'b0, 1'b1, 1);

        // Byte store drain
        drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h203, 32'hAB000000, 4'b1000);
        cyc("byte_push", 1'b0, 1'b1, 1);
        idle(); exp_wr(32'h200, 32'h00FFFFFF, 32'hAB000000);
        cyc("byte_drain", 1'b0, 1'b1, 0);
        idle(); cyc("byte_after", 1'b0, 1'b1, 1);

        // Starvation
        drive(1'b1, 32'h104, 2'd0, 1'b1, 32'h400, 32'h00000077, 4'b1111);
        exp_rd(32'h104); exp_resp(2'd0, 32'hCAFEF00D);
        cyc("stv_a", 1'b1, 1'b1, 1);
        drive(1'b1, 32'h108, 2'd1, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd(32'h108); exp_resp(2'd1, 32'h01234567);
        cyc("stv_win1", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h10C, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd(32'h10C); exp_resp(2'd2, 32'h89ABCDEF);
        cyc("stv_win2", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd(32'h100); exp_resp(2'd3, 32'hDEADBEEF);
        cyc("stv_win3", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h104, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wr(32'h400, 32'h00000000, 32'h00000077);
        cyc("stv_forced", 1'b0, 1'b1, 0);
        drive(1'b1, 32'h104, 2'd0, 1'b1, 32'h404, 32'h00000088, 4'b0011);
        exp_rd(32'h104); exp_resp(2'd0, 32'hCAFEF00D);
        cyc("stv_clear", 1'b1, 1'b1, 1);
        drive(1'b1, 32'h108, 2'd1, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_rd(32'h108); exp_resp(2'd1, 32'h01234567);
        cyc("stv_restart", 1'b1, 1'b1, 0);
        idle(); exp_wr(32'h404, 32'hFFFF0000, 32'h00000088);
        cyc("stv_drain2", 1'b0, 1'b1, 0);
        idle(); cyc("stv_empty", 1'b0, 1'b1, 1);

        // Full WB under a continuous load stream
        drive(1'b1, 32'h100, 2'd0, 1'b1, 32'h500, 32'hA0, 4'hF);
        exp_rd(32'h100); exp_resp(2'd0, 32'hDEADBEEF);
        cyc("full_c1", 1'b1, 1'b1, 1);
        drive(1'b1, 32'h104, 2'd1, 1'b1, 32'h504, 32'hA1, 4'hF);
        exp_rd(32'h104); exp_resp(2'd1, 32'hCAFEF00D);
        cyc("full_c2", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h108, 2'd2, 1'b1, 32'h508, 32'hA2, 4'hF);
        exp_rd(32'h108); exp_resp(2'd2, 32'h01234567);
        cyc("full_c3", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h10C, 2'd3, 1'b1, 32'h50C, 32'hA3, 4'hF);
        exp_rd(32'h10C); exp_resp(2'd3, 32'h89ABCDEF);
        cyc("full_c4", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h100, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wr(32'h500, 32'h0, 32'hA0);
        cyc("full_c5", 1'b0, 1'b0, 0);
        drive(1'b1, 32'h100, 2'd0, 1'b1, 32'h510, 32'hA4, 4'hF);
        exp_rd(32'h100); exp_resp(2'd0, 32'hDEADBEEF);
        cyc("full_c6", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h104, 2'd1, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wr(32'h504, 32'h0, 32'hA1);
        cyc("full_c7", 1'b0, 1'b0, 0);
        exp_rd(32'h104); exp_resp(2'd1, 32'hCAFEF00D);
        cyc("full_c8", 1'b1, 1'b1, 0);
        idle(); exp_wr(32'h508, 32'h0, 32'hA2);
        cyc("full_c9", 1'b0, 1'b1, 0);
        exp_wr(32'h50C, 32'h0, 32'hA3);
        cyc("full_c10", 1'b0, 1'b1, 0);
        exp_wr(32'h510, 32'h0, 32'hA4);
        cyc("full_c11", 1'b0, 1'b1, 0);
        cyc("full_c12", 1'b0, 1'b1, 1);

        // Conflict with a full-mask store
        drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h300, 32'h11223344, 4'b1111);
        cyc("cfl_push", 1'b0, 1'b1, 1);
        drive(1'b1, 32'h302, 2'd1, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wr(32'h300, 32'h0, 32'h11223344);
`ifdef WB_FWD_EN
        exp_resp(2'd1, 32'h11223344);
        cyc("cfl_fwd", 1'b1, 1'b1, 0);
        idle();
        cyc("cfl_fwd_resp", 1'b0, 1'b1, 1);
`else
        cyc("cfl_block", 1'b0, 1'b1, 0);
        exp_rd(32'h300); exp_resp(2'd1, 32'h11223344);
        cyc("cfl_grant", 1'b1, 1'b1, 1);
        idle();
`endif
        cyc("cfl_after", 1'b0, 1'b1, 1);

        // Conflict with a partial-mask store blocks in every build
        drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h600, 32'h000000EE, 4'b0001);
        cyc("part_push", 1'b0, 1'b1, 1);
        drive(1'b1, 32'h600, 2'd2, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wr(32'h600, 32'hFFFFFF00, 32'h000000EE);
        cyc("part_block", 1'b0, 1'b1, 0);
        exp_rd(32'h600); exp_resp(2'd2, 32'h123456EE);
        cyc("part_grant", 1'b1, 1'b1, 1);
        idle(); cyc("part_after", 1'b0, 1'b1, 1);

        // Reset mid-operation: response pending, WB count 3
        drive(1'b1, 32'h100, 2'd0, 1'b1, 32'h700, 32'hB0, 4'hF);
        exp_rd(32'h100); exp_resp(2'd0, 32'hDEADBEEF);
        cyc("rst_c1", 1'b1, 1'b1, 1);
        drive(1'b1, 32'h104, 2'd1, 1'b1, 32'h704, 32'hB1, 4'hF);
        exp_rd(32'h104); exp_resp(2'd1, 32'hCAFEF00D);
        cyc("rst_c2", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h108, 2'd2, 1'b1, 32'h708, 32'hB2, 4'hF);
        exp_rd(32'h108); exp_resp(2'd2, 32'h01234567);
        cyc("rst_c3", 1'b1, 1'b1, 0);
        drive(1'b1, 32'h10C, 2'd3, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        exp_rd(32'h10C);
        cyc("rst_c4", 1'b1, 1'b1, 0);
        rst = 1'b1;
        idle();
        @(negedge clk);
        check("rst_mid_resp_valid", {31'h0, bus.ld_resp_valid}, 32'h0);
        check("rst_mid_resp_tag", {30'h0, bus.ld_resp_tag}, 32'h0);
        check("rst_mid_resp_data", bus.ld_resp_data, 32'h0);
        check("rst_mid_wb_empty", {31'h0, bus.wb_empty}, 32'h1);
        check("rst_mid_dm_c_en", {31'h0, bus.DM_c_en}, 32'h0);
        @(posedge clk);
        #1;
        cyc("final_idle", 1'b0, 1'b1, 1);

        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        check("dm_q_drained", 32'(dm_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Owns the single data-memory (DM) port and shares it between two requesters:
  - out-of-order load requests issued by the LSU;
  - committed stores, parked in an internal write buffer (WB).
- Only committed stores enter the WB, so its contents are never flushed by mispredicts.
- Issues one DM access per cycle. Loads have priority over store drain, bounded by a starvation limit. Loads that hit a pending WB word are held back until that word drains.

Parameters:
- WB_DEPTH, 4, number of write-buffer entries (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty WB may lose arbitration before a drain is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- ld_req_valid  in  1  load request present.
- ld_req_ready  out  1  load accepted this cycle.
- ld_req_addr  in  32  load byte address.
- ld_req_tag  in  2  LQ index, returned with the response.
- ld_resp_valid  out  1  load data valid.
- ld_resp_tag  out  2  tag of the returning load.
- ld_resp_data  out  32  raw aligned word; the LSU performs sign/zero extension.
- st_valid  in  1  committed store push.
- st_ready  out  1  WB has space.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, already lane-aligned.
- st_bmask  in  4  byte enables, active-high.
- wb_empty  out  1  WB holds no entries (used for fence/drain).
- DM_rd_data  in  32  DM read data, valid 1 cycle after the read.
- DM_c_en  out  1  high when a DM access is performed this cycle.
- DM_r_en  out  1  1 = read, 0 = write.
- DM_w_en  out  32  bit write enable, active-low (0 = write the bit); all-ones when not writing.
- DM_addr  out  32  access address.
- DM_w_data  out  32  write data.

Behaviour:
- Reset (rst=0 at a clock edge), regardless of in-flight activity:
  - WB head, tail and count = 0; starve counter = 0.
  - ld_resp_valid = 0, ld_resp_tag = 0, ld_resp_data = 0.
  - Any pending response is dropped.
- st_ready = (count < WB_DEPTH).
  - A push while full is a protocol error.
  - A push and a drain in the same cycle are legal at any count.
  - Drain frees a slot only at the next edge, so st_ready is not combinationally raised by a drain.
- Conflict: the load is blocked when any valid WB entry has entry.addr[31:2] == ld_req_addr[31:2].
- Grant order, evaluated per cycle:
  1. Drain the WB head if WB is non-empty and any of these holds: count == WB_DEPTH, starve == STARVE_LIMIT, !ld_req_valid, or the load is conflict-blocked.
  2. Otherwise grant the load when ld_req_valid.
  3. Otherwise idle: DM_c_en = 0, DM_r_en = 1, DM_w_en = all-ones.
- Starve counter:
  - Increments when WB is non-empty and a load wins.
  - Clears on a drain or when WB is empty.
  - Saturates at STARVE_LIMIT.
- Load grant:
  - ld_req_ready = 1, DM_c_en = 1, DM_r_en = 1, DM_addr = {ld_req_addr[31:2], 2'b00}.
  - Next cycle: ld_resp_valid = 1, ld_resp_tag = registered tag, ld_resp_data = DM_rd_data.
  - Fixed latency of 1; the response cannot be back-pressured.
- Drain:
  - DM_c_en = 1, DM_r_en = 0, DM_addr = {head.addr[31:2], 2'b00}, DM_w_data = head.data.
  - Each byte lane k where bmask[k] = 1 drives DM_w_en[8k+7:8k] = 8'h00; all other bits are 1.
  - Head advances modulo WB_DEPTH.
- ld_req_ready = 0 whenever the load is not granted, including conflict-blocked and drain-forced cycles.
- A same-cycle st push is not yet visible to the conflict check.
  - The LSU guarantees it never issues a load to a word being committed in the same cycle.
- Pointers wrap modulo WB_DEPTH. count is tracked separately so full and empty are unambiguous.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - A conflicting load whose youngest matching WB entry has bmask == 4'b1111 is granted without a DM read.
  - Next cycle: ld_resp_data = that entry's data, ld_resp_valid = 1.
  - The DM port is free that cycle and drains the WB head if non-empty.
  - A partial-mask match still blocks the load.
- Undefined: every conflicting load blocks until the matching entries drain.

Decomposition:
- Package dm_arb_pkg holds:
  - typedef wb_entry_t {addr[31:0], data[31:0], bmask[3:0], valid};
  - constants DM_WEN_NONE = 32'hFFFF_FFFF, LANE_W = 8.
- Sub-module dm_write_buffer: circular FIFO with push/pop, count, and a per-entry word-address compare vector (plus youngest-full-match data under WB_FWD_EN).
- dm_port_arbiter holds the grant logic, starve counter and response register.

Test Plan:
- Lone load: ld addr 0x100, tag 2, DM word 0xDEADBEEF → ld_req_ready=1 and DM_addr=0x100 the same cycle; next cycle ld_resp_valid=1, tag=2, data=0xDEADBEEF.
- Byte store drain: push st 0x203, data 0xAB000000, bmask 4'b1000 with no loads → next cycle DM_r_en=0, DM_addr=0x200, DM_w_en=0x00FFFFFF, wb_empty=1 afterwards.
- Starvation: 1 WB entry with ld_req_valid held high on non-conflicting addresses → loads win 3 cycles, the 4th cycle drains, then the starve counter is 0.
- Full WB: push 4 stores with a continuous load stream → st_ready=0 at count 4, a drain is forced each cycle until count < 4, and loads stall meanwhile.
- Conflict: WB holds st 0x300 (bmask 1111, data 0x11223344); load 0x302 → blocked (ready=0) while the store drains, granted the cycle after. With WB_FWD_EN: granted immediately, resp data 0x11223344, and the store drains in that same cycle.
- Reset mid-operation: rst=0 while a load response is pending and WB has count 3 → next cycle ld_resp_valid=0, wb_empty=1, and no DM access.
